cla_shared_adder_ctrl: RTL
==========================

Name: cla_shared_adder_ctrl

Overview:
- Shares one CLA_4bit nibble adder between two requesters and computes WIDTH-bit sums nibble-serially, LSB nibble first.
- Each requester has its own valid/ready operand port. Results go out on one valid/ready result port tagged with the requester id.
- Sits between operand sources and the existing 4-bit carry-lookahead datapath. It trades latency for area: one adder serves any WIDTH.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble passes per operation (derived; do not override).

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_sum  out  WIDTH  sum bits.
- res_cout  out  1  carry out of the MSB.
- res_id  out  1  requester that issued this result.

Behaviour:
- Reset: asynchronous, active-high; clock CLK.
  - While reset is high, state=IDLE, operand/sum/carry/nibble-counter registers are 0, last_grant=1 (so req0 wins first).
  - res_valid=0, res_sum=0, res_cout=0, res_id=0, both ready=0.
- States:
  - IDLE: wait for a request.
  - CALC: nibble passes.
  - DONE: hold result.
- Arbitration, IDLE only, combinational:
  - If one valid is high, grant that requester.
  - If both are high, grant the requester other than last_grant.
  - reqN_ready = (state==IDLE) && granted(N). At most one ready is ever high.
  - A lone requester is granted every time.
- Accept edge (ready & valid):
  - Capture A, B, cin into internal registers; res_id<=N; last_grant<=N; nibble counter k<=0.
  - IDLE->CALC.
- CALC:
  - The CLA is driven with A[4k+3:4k], B[4k+3:4k] and the carry register (captured cin for k=0).
  - Each edge writes the CLA sum into sum[4k+3:4k], carry<=CLA cout, k<=k+1.
  - After the edge with k==NIB-1: res_cout<=CLA cout, CALC->DONE, res_valid<=1.
- Latency: res_valid rises NIB edges after the accept edge (4 for WIDTH=16).
- DONE:
  - res_sum/res_cout/res_id are stable while res_valid && !res_ready.
  - On res_valid && res_ready: res_valid<=0, DONE->IDLE.
  - No accept happens in the same cycle; one bubble.
  - Throughput: one result per NIB+2 cycles under continuous load.
- Arithmetic: {res_cout,res_sum} = A+B+cin, modulo 2^(WIDTH+1). All-ones + all-ones + 1 gives sum all-ones, cout 1.
- Input changes on a requester port after its accept edge have no effect on the current operation.
- reset mid-operation: the operation is abandoned with no result emitted. The block returns to the reset values above, and the first IDLE cycle after reset deasserts can accept again.
- res_sum is held at its last value in IDLE until the next DONE, but is only meaningful while res_valid=1.

Decomposition:
- Shared package:
  - state enum {IDLE, CALC, DONE};
  - nibble width constant 4;
  - requester id constants REQ0=0, REQ1=1.
- One sub-module: the existing CLA_4bit, instantiated once, unchanged.
- Arbiter, nibble mux and state machine stay inline in this module.

Test Plan:
- Full carry ripple (WIDTH=16): req0 A=16'hFFFF, B=16'h0001, cin=0 -> res_valid exactly 4 cycles after accept; res_sum=16'h0000, res_cout=1, res_id=0.
- Carry-in with no carry-out: req1 A=16'h1234, B=16'h4321, cin=1 -> res_sum=16'h5556, res_cout=0, res_id=1.
- Simultaneous requests after reset: both valid (req0 8+7+0, req1 16'hFFFF+16'hFFFF+1), res_ready=1 ->
  - first result res_id=0, sum=16'h000F, cout=0;
  - then res_id=1, sum=16'hFFFF, cout=1;
  - then a fresh req0 request is granted next (alternation holds).
- Backpressure: hold res_ready=0 for 3 cycles after res_valid rises -> result held stable, both ready stay 0. Raise res_ready -> result taken, accept possible on the following cycle.
- Reset mid-operation: assert reset 2 cycles into CALC -> all outputs 0 immediately. After deassertion, res_valid never rises for the abandoned operation, and req0_ready is 1 in the first IDLE cycle.
- Random sweep of 1000 operations against a reference model, mixed valid/res_ready patterns -> zero mismatches, no lost or duplicated results.

Source files
------------

// File: rtl/cla_shared_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial shared CLA adder controller.
package cla_shared_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/cla_shared_adder_ctrl_cla.sv
// 4-bit carry-lookahead adder: the existing nibble datapath shared by the controller.
module CLA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

endmodule

// File: rtl/cla_shared_adder_ctrl.sv
// Two-requester front end that computes WIDTH-bit sums through one shared CLA_4bit,
// one nibble per cycle, LSB first; results are tagged with the requester id.
module cla_shared_adder_ctrl
    import cla_shared_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
);

    localparam int NIB = WIDTH / NIB_W;
    localparam int K_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [K_W-1:0]   k_q;
    logic             last_grant_q;
    logic             res_cout_q;
    logic             res_id_q;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             last_nib;
    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic [NIB_W-1:0] nib_sum;
    logic             nib_cout;

    // On contention the requester that did not win last time is granted.
    assign grant0 = req0_valid && (!req1_valid || (last_grant_q == REQ1));
    assign grant1 = req1_valid && (!req0_valid || (last_grant_q == REQ0));

    assign req0_ready = !reset && (state_q == IDLE) && grant0;
    assign req1_ready = !reset && (state_q == IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;
    assign last_nib   = (k_q == K_W'(NIB - 1));

    assign nib_a = a_q[k_q*NIB_W +: NIB_W];
    assign nib_b = b_q[k_q*NIB_W +: NIB_W];

    CLA_4bit u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)    state_d = CALC;
            CALC:    if (last_nib)  state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            k_q          <= '0;
            last_grant_q <= REQ1;
            res_cout_q   <= 1'b0;
            res_id_q     <= REQ0;
        end else if (accept) begin
            a_q          <= req1_ready ? req1_a   : req0_a;
            b_q          <= req1_ready ? req1_b   : req0_b;
            carry_q      <= req1_ready ? req1_cin : req0_cin;
            res_id_q     <= req1_ready ? REQ1     : REQ0;
            last_grant_q <= req1_ready ? REQ1     : REQ0;
            k_q          <= '0;
        end else if (state_q == CALC) begin
            sum_q[k_q*NIB_W +: NIB_W] <= nib_sum;
            carry_q                   <= nib_cout;
            k_q                       <= k_q + 1'b1;
            if (last_nib) begin
                res_cout_q <= nib_cout;
            end
        end
    end

    assign res_valid = (state_q == DONE);
    assign res_sum   = sum_q;
    assign res_cout  = res_cout_q;
    assign res_id    = res_id_q;

endmodule
